// File: rtl/ifu_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// ifu_fetch_ctrl
//
// Multi-cycle instruction fetch unit for the NPC core. It owns the fetch PC,
// issues one read per instruction on a valid/ready instruction-memory bus,
// holds the fetched word until the decode stage accepts it, and then waits
// for the execute/writeback side to supply the next PC. At most one
// instruction is in flight.
//
// Optional feature (compile-time macro):
//   IFU_ALIGN_CHECK_EN - when defined, a misaligned next_pc (bits [1:0] != 0)
//                        accepted from the back end sends the unit straight
//                        to the error state without a bus request. When not
//                        defined, the bus address is forced word-aligned and
//                        pc reports the unmasked value.
//
// Ports:
//   clk, rst                  core clock, synchronous active-high reset
//   araddr/arvalid/arready    instruction read request channel
//   rdata/rresp/rvalid/rready instruction read response channel
//   inst/pc/inst_valid/inst_ready       fetched instruction to the IDU
//   next_pc/next_pc_valid/next_pc_ready next fetch address from EXU/WBU
//   fetch_err                 sticky error flag; unit halted until rst
//   fetch_cnt                 instructions handed to the IDU (wraps)
// ----------------------------------------------------------------------------
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic [31:0] next_pc,
  input  logic        next_pc_valid,
  output logic        next_pc_ready,
  output logic        fetch_err,
  output logic [31:0] fetch_cnt
);

  localparam logic [2:0] S_REQ       = 3'd0;
  localparam logic [2:0] S_WAIT      = 3'd1;
  localparam logic [2:0] S_HOLD      = 3'd2;
  localparam logic [2:0] S_WAIT_NEXT = 3'd3;
  localparam logic [2:0] S_ERR       = 3'd4;

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic [31:0] fetch_pc;
  logic        next_pc_misaligned;

  // Handshakes are qualified by the registered valid/ready outputs, so any
  // input strobe arriving outside its owning state is ignored for free.
  logic ar_fire;
  logic r_fire;
  logic i_fire;
  logic n_fire;

  assign ar_fire = arvalid & arready;
  assign r_fire  = rready & rvalid;
  assign i_fire  = inst_valid & inst_ready;
  assign n_fire  = next_pc_ready & next_pc_valid;

`ifdef IFU_ALIGN_CHECK_EN
  assign next_pc_misaligned = |next_pc[1:0];
  assign araddr             = fetch_pc;
`else
  assign next_pc_misaligned = 1'b0;
  assign araddr             = {fetch_pc[31:2], 2'b00};
`endif

  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_REQ:       if (ar_fire) state_next = S_WAIT;
      S_WAIT:      if (r_fire)  state_next = (rresp == 2'b00) ? S_HOLD : S_ERR;
      S_HOLD:      if (i_fire)  state_next = S_WAIT_NEXT;
      S_WAIT_NEXT: if (n_fire)  state_next = next_pc_misaligned ? S_ERR : S_REQ;
      S_ERR:       state_next = S_ERR;
      default:     state_next = S_REQ;
    endcase
  end

  // Valid/ready outputs are registered copies of the next-state decode. This
  // keeps them free of combinational input paths and holds arvalid low for
  // the whole reset period; the first request appears one edge after rst
  // is released.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_REQ;
      fetch_pc      <= RESET_PC;
      pc            <= RESET_PC;
      inst          <= 32'h0;
      arvalid       <= 1'b0;
      rready        <= 1'b0;
      inst_valid    <= 1'b0;
      next_pc_ready <= 1'b0;
      fetch_err     <= 1'b0;
      fetch_cnt     <= 32'h0;
    end else begin
      state         <= state_next;
      arvalid       <= (state_next == S_REQ);
      rready        <= (state_next == S_WAIT);
      inst_valid    <= (state_next == S_HOLD);
      next_pc_ready <= (state_next == S_WAIT_NEXT);
      fetch_err     <= (state_next == S_ERR);

      // Any response (good or bad) publishes the fetch address on pc, so a
      // bus error leaves the faulting address visible.
      if (r_fire) begin
        pc <= fetch_pc;
        if (rresp == 2'b00) inst <= rdata;
      end

      if (i_fire) fetch_cnt <= fetch_cnt + 32'd1;

      if (n_fire) begin
        fetch_pc <= next_pc;
        // A misaligned target never reaches the bus; report it directly.
        if (next_pc_misaligned) pc <= next_pc;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ifu_fetch_ctrl
//
// Directed bench for ifu_fetch_ctrl. The bench plays the instruction memory,
// the IDU and the next-PC source. Each good response it returns pushes the
// expected {inst, pc} onto a scoreboard queue; the entry is popped and
// compared when the DUT presents inst_valid.
// ----------------------------------------------------------------------------
module tb_ifu_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] next_pc;
  logic        next_pc_valid;
  logic        next_pc_ready;
  logic        fetch_err;
  logic [31:0] fetch_cnt;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  ifu_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .araddr       (araddr),
    .arvalid      (arvalid),
    .arready      (arready),
    .rdata        (rdata),
    .rresp        (rresp),
    .rvalid       (rvalid),
    .rready       (rready),
    .inst         (inst),
    .pc           (pc),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .next_pc      (next_pc),
    .next_pc_valid(next_pc_valid),
    .next_pc_ready(next_pc_ready),
    .fetch_err    (fetch_err),
    .fetch_cnt    (fetch_cnt)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled at the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Serve one instruction read. Entered in REQ with arvalid expected high.
  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] exp_pc,
                       input logic [31:0] data, input logic [1:0] resp,
                       input int ar_dly, input int r_dly);
    check("arvalid_req", {31'b0, arvalid}, 32'd1);
    check("araddr_req", araddr, exp_addr);
    arready = 1'b0;
    for (int i = 0; i < ar_dly; i++) begin
      step();
      check("arvalid_stable", {31'b0, arvalid}, 32'd1);
      check("araddr_stable", araddr, exp_addr);
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    check("rready_wait", {31'b0, rready}, 32'd1);
    check("arvalid_dropped", {31'b0, arvalid}, 32'd0);
    for (int i = 0; i < r_dly; i++) begin
      step();
      check("single_request", {31'b0, arvalid}, 32'd0);
      check("no_early_valid", {31'b0, inst_valid}, 32'd0);
    end
    rvalid = 1'b1;
    rdata  = data;
    rresp  = resp;
    if (resp == 2'b00) sb.push_back('{inst: data, pc: exp_pc});
    step();
    rvalid = 1'b0;
    rresp  = 2'b00;
    rdata  = $urandom;
    check("rready_dropped", {31'b0, rready}, 32'd0);
  endtask

  // Hand the held instruction to the IDU after `hold` stalled cycles.
  task automatic accept(input int hold, input logic [31:0] exp_cnt);
    exp_t e;
    check("inst_valid_rise", {31'b0, inst_valid}, 32'd1);
    check("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("inst", inst, e.inst);
      check("pc", pc, e.pc);
      inst_ready    = 1'b0;
      // A next_pc offered during HOLD must be ignored.
      next_pc       = 32'hdead_bee0;
      next_pc_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        rdata = $urandom;
        step();
        check("inst_hold", inst, e.inst);
        check("pc_hold", pc, e.pc);
        check("inst_valid_hold", {31'b0, inst_valid}, 32'd1);
        check("npc_ready_hold", {31'b0, next_pc_ready}, 32'd0);
      end
      next_pc_valid = 1'b0;
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    check("fetch_cnt", fetch_cnt, exp_cnt);
    check("inst_valid_fall", {31'b0, inst_valid}, 32'd0);
    check("npc_ready", {31'b0, next_pc_ready}, 32'd1);
  endtask

  task automatic give_next(input logic [31:0] addr);
    next_pc       = addr;
    next_pc_valid = 1'b1;
    step();
    next_pc_valid = 1'b0;
    check("npc_ready_fall", {31'b0, next_pc_ready}, 32'd0);
  endtask

  task automatic check_reset_values();
    check("rst_arvalid", {31'b0, arvalid}, 32'd0);
    check("rst_rready", {31'b0, rready}, 32'd0);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_npc_ready", {31'b0, next_pc_ready}, 32'd0);
    check("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
    check("rst_fetch_cnt", fetch_cnt, 32'd0);
    check("rst_pc", pc, RESET_PC);
    check("rst_inst", inst, 32'd0);
    check("rst_araddr", araddr, RESET_PC);
  endtask

  initial begin
    rst           = 1'b1;
    arready       = 1'b0;
    rdata         = 32'h0;
    rresp         = 2'b00;
    rvalid        = 1'b0;
    inst_ready    = 1'b0;
    next_pc       = 32'h0;
    next_pc_valid = 1'b0;

    // Reset values.
    repeat (3) step();
    check_reset_values();
    rst = 1'b0;
    step();

    // Zero-wait fetch of the first instruction.
    fetch(RESET_PC, RESET_PC, 32'h0000_0413, 2'b00, 0, 0);
    accept(0, 32'd1);
    give_next(32'h8000_0004);

    // Slow memory: arready after 3 cycles, rvalid 2 cycles later; the IDU
    // stalls 5 cycles while rdata toggles.
    fetch(32'h8000_0004, 32'h8000_0004, 32'h0fc0_006f, 2'b00, 3, 2);
    accept(5, 32'd2);
    give_next(32'h8000_0100);

    // Jump target.
    fetch(32'h8000_0100, 32'h8000_0100, 32'h0010_0093, 2'b00, 0, 0);
    accept(0, 32'd3);
    give_next(32'h8000_0008);

    // Bus error on the fetch at 0x80000008.
    fetch(32'h8000_0008, 32'h8000_0008, 32'h1234_5678, 2'b10, 1, 1);
    check("err_flag", {31'b0, fetch_err}, 32'd1);
    check("err_pc", pc, 32'h8000_0008);
    inst_ready    = 1'b1;
    next_pc_valid = 1'b1;
    next_pc       = 32'h8000_0040;
    for (int i = 0; i < 4; i++) begin
      step();
      check("err_arvalid", {31'b0, arvalid}, 32'd0);
      check("err_rready", {31'b0, rready}, 32'd0);
      check("err_inst_valid", {31'b0, inst_valid}, 32'd0);
      check("err_npc_ready", {31'b0, next_pc_ready}, 32'd0);
      check("err_sticky", {31'b0, fetch_err}, 32'd1);
      check("err_pc_hold", pc, 32'h8000_0008);
      check("err_cnt_hold", fetch_cnt, 32'd3);
    end
    inst_ready    = 1'b0;
    next_pc_valid = 1'b0;

    // Reset recovers from the error state.
    rst = 1'b1;
    step();
    check_reset_values();
    rst = 1'b0;
    step();
    fetch(RESET_PC, RESET_PC, 32'h0000_0513, 2'b00, 0, 0);
    accept(0, 32'd1);
    give_next(32'h8000_0002);

`ifdef IFU_ALIGN_CHECK_EN
    // Misaligned target goes straight to the error state.
    check("align_err", {31'b0, fetch_err}, 32'd1);
    check("align_pc", pc, 32'h8000_0002);
    for (int i = 0; i < 3; i++) begin
      step();
      check("align_no_arvalid", {31'b0, arvalid}, 32'd0);
    end
`else
    // Misaligned target: bus address masked, pc keeps the full value.
    fetch(32'h8000_0000, 32'h8000_0002, 32'h0000_0613, 2'b00, 0, 0);
    accept(0, 32'd2);
    check("noalign_err", {31'b0, fetch_err}, 32'd0);
`endif

    check("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
